// File: rtl/smpl_pkg.sv
// Shared opcodes, system codes and FSM state type for the smpl_vhdl accumulator CPU.
package smpl_pkg;

  localparam logic [2:0] OP_SYS = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_STA = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_JN  = 3'b111;

  localparam logic [7:0] SYS_NOP  = 8'h00;
  localparam logic [7:0] SYS_PUSH = 8'h01;
  localparam logic [7:0] SYS_POP  = 8'h02;
  localparam logic [7:0] SYS_HALT = 8'h1F;

  localparam logic [4:0] SP_RESET = 5'h1F;

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StHalt
  } state_e;

endpackage

// File: rtl/smpl_alu.sv
// Combinational ALU: load/pass-through, add and subtract, with zero and negative flags.
module smpl_alu
  import smpl_pkg::*;
(
  input  logic [7:0] acc,
  input  logic [7:0] operand,
  input  logic [2:0] op,
  output logic [7:0] result,
  output logic       z,
  output logic       n
);

  always_comb begin
    unique case (op)
      OP_ADD:  result = acc + operand;
      OP_DEC:  result = acc - operand;
      // LDA and POP both just load the memory operand.
      default: result = operand;
    endcase
    z = (result == 8'h00);
    n = result[7];
  end

endmodule

// File: rtl/smpl_vhdl.sv
// Two-cycle (fetch/exec) 8-bit accumulator CPU with Harvard memories and a
// hardware stack growing down from the top of data memory.
module smpl_vhdl
  import smpl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic       rd_mem,
  output logic       wr_mem,
  output logic [4:0] im_abus,
  input  logic [7:0] im_dbus,
  output logic [4:0] dm_abus,
  input  logic [7:0] dm_in_dbus,
  output logic [7:0] dm_out_dbus
);

  state_e     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [4:0] sp_q, sp_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic       z_q, z_d;
  logic       n_q, n_d;

  logic [2:0] op;
  logic [4:0] addr;
  logic [7:0] alu_result;
  logic       alu_z, alu_n;

  assign op   = ir_q[7:5];
  assign addr = ir_q[4:0];

  smpl_alu u_alu (
    .acc     (acc_q),
    .operand (dm_in_dbus),
    .op      (op),
    .result  (alu_result),
    .z       (alu_z),
    .n       (alu_n)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: state_d = StExec;
      StExec:  state_d = (ir_q == SYS_HALT) ? StHalt : StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Memory strobes and data address, decoded only in EXEC
  always_comb begin
    rd_mem  = 1'b0;
    wr_mem  = 1'b0;
    dm_abus = 5'h00;
    if (state_q == StExec) begin
      unique case (op)
        OP_LDA, OP_ADD, OP_DEC: begin
          rd_mem  = 1'b1;
          dm_abus = addr;
        end
        OP_STA: begin
          wr_mem  = 1'b1;
          dm_abus = addr;
        end
        OP_SYS: begin
          if (ir_q == SYS_PUSH) begin
            wr_mem  = 1'b1;
            dm_abus = sp_q;
          end else if (ir_q == SYS_POP) begin
            rd_mem  = 1'b1;
            dm_abus = sp_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign im_abus     = pc_q;
  assign dm_out_dbus = acc_q;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= 5'h00;
      ir_q  <= 8'h00;
      acc_q <= 8'h00;
      sp_q  <= SP_RESET;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      acc_q <= acc_d;
      sp_q  <= sp_d;
      z_q   <= z_d;
      n_q   <= n_d;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    acc_d = acc_q;
    sp_d  = sp_q;
    z_d   = z_q;
    n_d   = n_q;
    unique case (state_q)
      StFetch: begin
        ir_d = im_dbus;
        pc_d = pc_q + 5'd1;
      end
      StExec: begin
        unique case (op)
          OP_LDA, OP_ADD, OP_DEC: begin
            acc_d = alu_result;
            z_d   = alu_z;
            n_d   = alu_n;
          end
          OP_JMP: pc_d = addr;
          // Branches see flags left by earlier instructions.
          OP_JZ:  if (z_q) pc_d = addr;
          OP_JN:  if (n_q) pc_d = addr;
          OP_SYS: begin
            if (ir_q == SYS_PUSH) begin
              sp_d = sp_q - 5'd1;
            end else if (ir_q == SYS_POP) begin
              sp_d  = sp_q + 5'd1;
              acc_d = alu_result;
              z_d   = alu_z;
              n_d   = alu_n;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smpl_vhdl.sv
// Bench for smpl_vhdl: directed programs plus random programs checked against an
// instruction-level model of the CPU and its data memory.
module tb_smpl_vhdl;

  logic       clk;
  logic       reset;
  logic       rd_mem, wr_mem;
  logic [4:0] im_abus, dm_abus;
  logic [7:0] im_dbus, dm_in_dbus, dm_out_dbus;

  logic [7:0] imem [32];
  logic [7:0] dmem [32];
  logic [7:0] mdm  [32];

  logic       tb_we;
  logic [4:0] tb_addr;
  logic [7:0] tb_data;

  int n_checks;
  int n_pass;

  // Instruction-level model state
  int         m_pc, m_acc, m_sp;
  bit         m_z, m_n, m_halt;
  logic [4:0] last_addr;

  smpl_vhdl dut (
    .clk         (clk),
    .reset       (reset),
    .rd_mem      (rd_mem),
    .wr_mem      (wr_mem),
    .im_abus     (im_abus),
    .im_dbus     (im_dbus),
    .dm_abus     (dm_abus),
    .dm_in_dbus  (dm_in_dbus),
    .dm_out_dbus (dm_out_dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign im_dbus    = imem[im_abus];
  assign dm_in_dbus = dmem[dm_abus];

  // Data RAM writes on the falling edge; bench preload takes priority.
  always @(negedge clk) begin
    if (tb_we) dmem[tb_addr] <= tb_data;
    else if (wr_mem) dmem[dm_abus] <= dm_out_dbus;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void set_acc(input int v);
    m_acc = v;
    m_z   = (v == 0);
    m_n   = (v >= 128);
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) begin
      imem[i] = 8'h1F;
      mdm[i]  = 8'h00;
    end
  endtask

  task automatic do_reset(input bit load);
    reset = 1'b0;
    if (load) begin
      for (int i = 0; i < 32; i++) begin
        tb_addr = 5'(i);
        tb_data = mdm[i];
        tb_we   = 1'b1;
        @(negedge clk);
        #1;
      end
    end
    tb_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", int'(im_abus), 0);
    check("rst_rd", int'(rd_mem), 0);
    check("rst_wr", int'(wr_mem), 0);
    check("rst_dm_abus", int'(dm_abus), 0);
    check("rst_acc", int'(dm_out_dbus), 0);
    reset  = 1'b1;
    m_pc   = 0;
    m_acc  = 0;
    m_sp   = 31;
    m_z    = 1'b0;
    m_n    = 1'b0;
    m_halt = 1'b0;
  endtask

  // One instruction (or one halted cycle); entered and left 1 time unit after a rising edge.
  task automatic step();
    logic [7:0] ir;
    int op, a, ea;
    bit er, ew;
    if (m_halt) begin
      check("halt_rd", int'(rd_mem), 0);
      check("halt_wr", int'(wr_mem), 0);
      check("halt_pc", int'(im_abus), m_pc);
      @(posedge clk);
      #1;
      return;
    end
    check("fetch_pc", int'(im_abus), m_pc);
    check("fetch_rd", int'(rd_mem), 0);
    check("fetch_wr", int'(wr_mem), 0);
    check("acc", int'(dm_out_dbus), m_acc);
    ir   = imem[m_pc];
    m_pc = (m_pc + 1) % 32;
    @(posedge clk);
    #1;
    op = int'(ir[7:5]);
    a  = int'(ir[4:0]);
    er = 1'b0;
    ew = 1'b0;
    ea = 0;
    case (op)
      1, 2, 3: begin er = 1'b1; ea = a; end
      4:       begin ew = 1'b1; ea = a; end
      0: begin
        if (ir == 8'h01) begin ew = 1'b1; ea = m_sp; end
        else if (ir == 8'h02) begin er = 1'b1; ea = (m_sp + 1) % 32; end
      end
      default: ;
    endcase
    check("exec_rd", int'(rd_mem), int'(er));
    check("exec_wr", int'(wr_mem), int'(ew));
    if (er || ew) check("exec_addr", int'(dm_abus), ea);
    last_addr = dm_abus;
    case (op)
      1: set_acc(int'(mdm[a]));
      2: set_acc((m_acc + int'(mdm[a])) % 256);
      3: set_acc((m_acc - int'(mdm[a]) + 256) % 256);
      4: mdm[a] = 8'(m_acc);
      5: m_pc = a;
      6: if (m_z) m_pc = a;
      7: if (m_n) m_pc = a;
      default: begin
        if (ir == 8'h01) begin
          mdm[m_sp] = 8'(m_acc);
          m_sp = (m_sp + 31) % 32;
        end else if (ir == 8'h02) begin
          m_sp = (m_sp + 1) % 32;
          set_acc(int'(mdm[m_sp]));
        end else if (ir == 8'h1F) begin
          m_halt = 1'b1;
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mem_cmp();
    for (int i = 0; i < 32; i++) check($sformatf("dmem[%0d]", i), int'(dmem[i]), int'(mdm[i]));
  endtask

  task automatic load_stack_prog();
    clear_prog();
    imem[0]  = 8'h20; imem[1]  = 8'h01; imem[2]  = 8'h21; imem[3]  = 8'h01;
    imem[4]  = 8'h22; imem[5]  = 8'h01; imem[6]  = 8'h00; imem[7]  = 8'h02;
    imem[8]  = 8'h83; imem[9]  = 8'h02; imem[10] = 8'h84; imem[11] = 8'h02;
    imem[12] = 8'h85; imem[13] = 8'h1F;
    mdm[0] = 8'h01; mdm[1] = 8'h07; mdm[2] = 8'h05;
  endtask

  task automatic stack_results();
    check("stk_dm3", int'(dmem[3]), 8'h05);
    check("stk_dm4", int'(dmem[4]), 8'h07);
    check("stk_dm5", int'(dmem[5]), 8'h01);
    check("stk_dm31", int'(dmem[31]), 8'h01);
    check("stk_dm30", int'(dmem[30]), 8'h07);
    check("stk_dm29", int'(dmem[29]), 8'h05);
    check("stk_halt_pc", int'(im_abus), 14);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    tb_we    = 1'b0;
    tb_addr  = 5'h00;
    tb_data  = 8'h00;
    for (int i = 0; i < 32; i++) dmem[i] = 8'h00;

    // Stack
    load_stack_prog();
    do_reset(1'b1);
    run(17);
    stack_results();
    mem_cmp();

    // Arithmetic
    clear_prog();
    imem[0] = 8'h22; imem[1] = 8'h41; imem[2] = 8'h83; imem[3] = 8'hC0;
    mdm[1] = 8'h07; mdm[2] = 8'h05;
    do_reset(1'b1);
    run(4);
    check("arith_dm3", int'(dmem[3]), 8'h0C);
    check("arith_pc", int'(im_abus), 4);
    run(2);

    // Negative-result branch
    clear_prog();
    imem[0] = 8'h21; imem[1] = 8'h60; imem[2] = 8'h81; imem[3] = 8'h22;
    imem[4] = 8'h61; imem[5] = 8'h83; imem[6] = 8'hE4;
    mdm[0] = 8'h01; mdm[1] = 8'h07; mdm[2] = 8'h05;
    do_reset(1'b1);
    run(7);
    check("neg_dm1", int'(dmem[1]), 8'h06);
    check("neg_dm3", int'(dmem[3]), 8'hFF);
    check("neg_jn_pc", int'(im_abus), 4);
    run(6);
    mem_cmp();

    // Wrap: ADD to 0x100, then POP/PUSH around the SP boundary
    clear_prog();
    imem[0] = 8'h20; imem[1] = 8'h41; imem[2] = 8'hC5;
    imem[5] = 8'h02; imem[6] = 8'h01;
    mdm[0] = 8'h80; mdm[1] = 8'h80;
    do_reset(1'b1);
    run(3);
    check("wrap_acc", int'(dm_out_dbus), 0);
    check("wrap_jz_pc", int'(im_abus), 5);
    run(1);
    check("wrap_pop_addr", int'(last_addr), 0);
    run(1);
    check("wrap_push_addr", int'(last_addr), 0);
    run(2);
    mem_cmp();

    // Reset mid-program, then a full rerun from address 0
    load_stack_prog();
    do_reset(1'b1);
    run(5);
    do_reset(1'b0);
    run(17);
    stack_results();
    mem_cmp();

    // Random programs against the model
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) begin
        imem[i] = 8'($urandom);
        mdm[i]  = 8'($urandom);
      end
      do_reset(1'b1);
      run(48);
      mem_cmp();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
